// File: rtl/stream_golden_checker.sv
// stream_golden_checker: checks NCH valid-qualified streams against expected memories (STRM_CHK_TOL_EN enables tolerance compare)
module stream_golden_checker #(
    parameter int NCH     = 2,
    parameter int DW      = 8,
    parameter int N_EXP   = 527,
    parameter int AW      = 10,
    parameter int CW      = 16,
    parameter int MAX_CYC = 10000000,
    parameter int TOL     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NCH-1:0]    dut_valid,
    input  logic [NCH*DW-1:0] dut_data,
    output logic [NCH*AW-1:0] exp_addr,
    input  logic [NCH*DW-1:0] exp_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              overrun,
    output logic [NCH*CW-1:0] err_cnt,
    output logic [NCH*CW-1:0] pass_cnt,
    output logic [2:0]        first_err_ch,
    output logic [AW-1:0]     first_err_idx,
    output logic [DW-1:0]     first_err_got,
    output logic [DW-1:0]     first_err_exp
);
    localparam int CYW = $clog2(MAX_CYC) + 1;
    localparam logic [CYW-1:0] CYC_END = CYW'(MAX_CYC - 1);
    localparam logic [AW:0] NE = (AW + 1)'(N_EXP);
`ifdef STRM_CHK_TOL_EN
    localparam logic [DW:0] TOLV = (DW + 1)'(TOL);
`else
    localparam logic [DW:0] TOLV = (DW + 1)'(TOL - TOL);
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE, TOUT} state_t;
    state_t state, state_nx;

    logic [CYW-1:0] cyc;
    logic [AW:0]    idx [NCH];
    logic [NCH-1:0] sv;
    logic [DW-1:0]  sd [NCH];
    logic [AW-1:0]  stag [NCH];
    logic [CW-1:0]  ec [NCH];
    logic [CW-1:0]  pc [NCH];
    logic [DW:0]    dif [NCH];
    logic [NCH-1:0] acc, ovr, ok, mis, comp;
    logic           hit, fe_set;
    logic [2:0]     hit_ch;
    logic [AW-1:0]  hit_idx;
    logic [DW-1:0]  hit_got, hit_exp;

    // per-channel accept/compare decode and lowest-channel mismatch pick
    always_comb begin
        acc     = '0;
        ovr     = '0;
        ok      = '0;
        mis     = '0;
        comp    = '0;
        hit_ch  = '0;
        hit_idx = '0;
        hit_got = '0;
        hit_exp = '0;
        for (int c = 0; c < NCH; c++) begin
            acc[c]  = state == RUN && dut_valid[c] && idx[c] < NE;
            ovr[c]  = state == RUN && dut_valid[c] && idx[c] >= NE;
            dif[c]  = sd[c] >= exp_data[c*DW +: DW] ? {1'b0, sd[c]} - {1'b0, exp_data[c*DW +: DW]}
                                                     : {1'b0, exp_data[c*DW +: DW]} - {1'b0, sd[c]};
            ok[c]   = sv[c] && dif[c] <= TOLV;
            mis[c]  = sv[c] && dif[c] > TOLV;
            comp[c] = idx[c] == NE && !sv[c];
        end
        for (int c = NCH - 1; c >= 0; c--) begin
            if (mis[c]) begin
                hit_ch  = 3'(c);
                hit_idx = stag[c];
                hit_got = sd[c];
                hit_exp = exp_data[c*DW +: DW];
            end
        end
        hit = |mis;
    end

    // top-level next state: terminal DONE/TOUT are left only by reset
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = start ? RUN : IDLE;
        else if (state == RUN)
            state_nx = &comp ? DONE : (cyc == CYC_END ? TOUT : RUN);
    end

    // state register and RUN cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cyc   <= '0;
        end else begin
            state <= state_nx;
            cyc   <= state == RUN ? cyc + 1'b1 : '0;
        end
    end

    // per-channel index, stage register and saturating counters
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                idx[c]  <= '0;
                sd[c]   <= '0;
                stag[c] <= '0;
                sv[c]   <= 1'b0;
                ec[c]   <= '0;
                pc[c]   <= '0;
            end else begin
                if (acc[c]) begin
                    idx[c]  <= idx[c] + 1'b1;
                    sd[c]   <= dut_data[c*DW +: DW];
                    stag[c] <= idx[c][AW-1:0];
                end
                sv[c] <= acc[c];
                if (ok[c] && pc[c] != '1)
                    pc[c] <= pc[c] + 1'b1;
                if (mis[c] && ec[c] != '1)
                    ec[c] <= ec[c] + 1'b1;
            end
        end
    end

    // sticky overrun and one-shot first-mismatch capture
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun       <= 1'b0;
            fe_set        <= 1'b0;
            first_err_ch  <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else begin
            if (|ovr)
                overrun <= 1'b1;
            if (hit && !fe_set) begin
                fe_set        <= 1'b1;
                first_err_ch  <= hit_ch;
                first_err_idx <= hit_idx;
                first_err_got <= hit_got;
                first_err_exp <= hit_exp;
            end
        end
    end

    // pack per-channel registers onto the flat output buses
    always_comb begin
        exp_addr = '0;
        err_cnt  = '0;
        pass_cnt = '0;
        for (int c = 0; c < NCH; c++) begin
            exp_addr[c*AW +: AW] = idx[c][AW-1:0];
            err_cnt[c*CW +: CW]  = ec[c];
            pass_cnt[c*CW +: CW] = pc[c];
        end
    end

    assign done    = state == DONE || state == TOUT;
    assign timeout = state == TOUT;
    assign pass    = state == DONE && !overrun && ~|err_cnt;
endmodule

// File: tb/tb_stream_golden_checker.sv
// tb_stream_golden_checker: directed table-driven bench for stream_golden_checker
module tb_stream_golden_checker;
    localparam int NCH = 2, DW = 8, N_EXP = 4, AW = 2, CW = 16, MAX_CYC = 20;
    localparam logic [31:0] GOOD = 32'h40302010;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [NCH-1:0]    dut_valid;
    logic [NCH*DW-1:0] dut_data;
    logic [NCH*AW-1:0] exp_addr;
    logic [NCH*DW-1:0] exp_data;
    logic              done, pass, timeout, overrun;
    logic [NCH*CW-1:0] err_cnt, pass_cnt;
    logic [2:0]        first_err_ch;
    logic [AW-1:0]     first_err_idx;
    logic [DW-1:0]     first_err_got, first_err_exp;

    int total = 0;
    int bad = 0;

    stream_golden_checker #(.NCH(NCH), .DW(DW), .N_EXP(N_EXP), .AW(AW), .CW(CW),
                            .MAX_CYC(MAX_CYC), .TOL(1)) dut (
        .clk(clk), .reset(reset), .start(start), .dut_valid(dut_valid), .dut_data(dut_data),
        .exp_addr(exp_addr), .exp_data(exp_data), .done(done), .pass(pass), .timeout(timeout),
        .overrun(overrun), .err_cnt(err_cnt), .pass_cnt(pass_cnt), .first_err_ch(first_err_ch),
        .first_err_idx(first_err_idx), .first_err_got(first_err_got), .first_err_exp(first_err_exp)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [4];
    initial begin
        mem[0] = 8'h10;
        mem[1] = 8'h20;
        mem[2] = 8'h30;
        mem[3] = 8'h40;
    end

    always @(posedge clk) begin
        exp_data[7:0]  <= mem[exp_addr[1:0]];
        exp_data[15:8] <= mem[exp_addr[3:2]];
    end

    typedef struct packed {
        logic [31:0] d0, d1;
        logic        v1, x0;
        logic        dn, ps, to, ov;
        logic [15:0] e0, e1, p0, p1;
        logic [2:0]  fch;
        logic [1:0]  fidx;
        logic [7:0]  fgot, fexp;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        dut_valid = '0;
        dut_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive4(input logic [31:0] d0, input logic [31:0] d1, input logic v1);
        for (int k = 0; k < 4; k++) begin
            dut_valid = {v1, 1'b1};
            dut_data = {d1[k*8 +: 8], d0[k*8 +: 8]};
            @(negedge clk);
        end
        dut_valid = '0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, int'(done), 1);
    endtask

    initial begin
        tv[0] = '{GOOD, GOOD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd4, 16'd4,
                  3'd0, 2'd0, 8'h00, 8'h00};
        tv[1] = '{GOOD, 32'h40332010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1, 16'd4, 16'd3,
                  3'd1, 2'd2, 8'h33, 8'h30};
        tv[2] = '{32'h40302510, 32'h40302610, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1, 16'd3, 16'd3,
                  3'd0, 2'd1, 8'h25, 8'h20};
        tv[3] = '{GOOD, GOOD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd4, 16'd0,
                  3'd0, 2'd0, 8'h00, 8'h00};
        tv[4] = '{GOOD, GOOD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd4, 16'd4,
                  3'd0, 2'd0, 8'h00, 8'h00};
`ifdef STRM_CHK_TOL_EN
        tv[5] = '{32'h40312010, 32'h4030200F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd4, 16'd4,
                  3'd0, 2'd0, 8'h00, 8'h00};
`else
        tv[5] = '{32'h40312010, 32'h4030200F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1, 16'd3, 16'd3,
                  3'd1, 2'd0, 8'h0F, 8'h10};
`endif

        do_reset();
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_pass_cnt", int'(pass_cnt), 0);
        chk("rst_exp_addr", int'(exp_addr), 0);
        chk("rst_first_err", int'({first_err_ch, first_err_idx, first_err_got, first_err_exp}), 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            pulse_start();
            drive4(tv[i].d0, tv[i].d1, tv[i].v1);
            if (tv[i].x0) begin
                dut_valid = 2'b01;
                dut_data = 16'h0050;
                @(negedge clk);
                dut_valid = '0;
            end
            wait_done($sformatf("v%0d", i));
            chk($sformatf("v%0d_pass", i), int'(pass), int'(tv[i].ps));
            chk($sformatf("v%0d_timeout", i), int'(timeout), int'(tv[i].to));
            chk($sformatf("v%0d_overrun", i), int'(overrun), int'(tv[i].ov));
            chk($sformatf("v%0d_err0", i), int'(err_cnt[15:0]), int'(tv[i].e0));
            chk($sformatf("v%0d_err1", i), int'(err_cnt[31:16]), int'(tv[i].e1));
            chk($sformatf("v%0d_pass0", i), int'(pass_cnt[15:0]), int'(tv[i].p0));
            chk($sformatf("v%0d_pass1", i), int'(pass_cnt[31:16]), int'(tv[i].p1));
            chk($sformatf("v%0d_fe_ch", i), int'(first_err_ch), int'(tv[i].fch));
            chk($sformatf("v%0d_fe_idx", i), int'(first_err_idx), int'(tv[i].fidx));
            chk($sformatf("v%0d_fe_got", i), int'(first_err_got), int'(tv[i].fgot));
            chk($sformatf("v%0d_fe_exp", i), int'(first_err_exp), int'(tv[i].fexp));
        end

        // exact done latency: last compare lands one edge before DONE
        do_reset();
        pulse_start();
        drive4(GOOD, GOOD, 1'b1);
        @(negedge clk);
        chk("lat_done_early", int'(done), 0);
        chk("lat_pass_cnt", int'(pass_cnt), 32'h00040004);
        @(negedge clk);
        chk("lat_done", int'(done), 1);
        chk("lat_pass", int'(pass), 1);

        // exact timeout cycle with no valids at all
        do_reset();
        pulse_start();
        for (int k = 0; k < 19; k++) @(negedge clk);
        chk("to_early", int'(timeout), 0);
        @(negedge clk);
        chk("to_timeout", int'(timeout), 1);
        chk("to_done", int'(done), 1);
        chk("to_pass", int'(pass), 0);

        // reset mid-run, ignored valids in IDLE, then a clean re-check
        do_reset();
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            dut_valid = 2'b11;
            dut_data = {GOOD[k*8 +: 8], GOOD[k*8 +: 8]};
            @(negedge clk);
        end
        dut_valid = '0;
        @(negedge clk);
        chk("mid_pass_cnt_before", int'(pass_cnt), 32'h00020002);
        do_reset();
        chk("mid_pass_cnt", int'(pass_cnt), 0);
        chk("mid_exp_addr", int'(exp_addr), 0);
        dut_valid = 2'b11;
        dut_data = 16'h1010;
        @(negedge clk);
        @(negedge clk);
        dut_valid = '0;
        chk("idle_exp_addr", int'(exp_addr), 0);
        chk("idle_pass_cnt", int'(pass_cnt), 0);
        pulse_start();
        drive4(GOOD, GOOD, 1'b1);
        wait_done("rerun");
        chk("rerun_pass", int'(pass), 1);
        chk("rerun_pass_cnt", int'(pass_cnt), 32'h00040004);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_ignores_start", int'(done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_golden_checker.md
Name: stream_golden_checker

Overview:
- Synthesizable, parametrised successor to the two-channel golden-compare bench logic used for filter blocks such as MBF.
- Checks NCH valid-qualified DUT output streams against expected-value memories, one memory per channel.
- Counts pass and error samples per channel and captures the first mismatch.
- Raises done/pass when every channel has consumed N_EXP samples, or raises timeout when the cycle budget runs out.
- Sits beside the DUT in an FPGA or emulation harness, driven by the same clock.

Parameters:
- NCH, 2: number of checked channels (1..8).
- DW, 8: sample width, bits.
- N_EXP, 527: expected samples per channel.
- AW, 10: expected-memory address width; requires 2**AW >= N_EXP.
- CW, 16: width of the pass/error counters; counters saturate at all-ones.
- MAX_CYC, 10000000: cycle budget in RUN before timeout.
- TOL, 1: absolute tolerance, used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins checking.
- dut_valid  in  NCH  per-channel sample strobe.
- dut_data  in  NCH*DW  channel c occupies bits [c*DW +: DW].
- exp_addr  out  NCH*AW  per-channel read address into expected memory.
- exp_data  in  NCH*DW  expected sample; synchronous-read memory, valid 1 cycle after exp_addr.
- done  out  1  test finished (all channels complete, or timeout).
- pass  out  1  done with zero errors, no overrun and no timeout.
- timeout  out  1  cycle budget exceeded.
- overrun  out  1  sticky; a valid arrived on an already-complete channel.
- err_cnt  out  NCH*CW  per-channel mismatch count.
- pass_cnt  out  NCH*CW  per-channel match count.
- first_err_ch  out  3  channel of the first mismatch.
- first_err_idx  out  AW  sample index of the first mismatch.
- first_err_got  out  DW  DUT value at the first mismatch.
- first_err_exp  out  DW  expected value at the first mismatch.

Behaviour:
- Reset values: every output 0; state IDLE; all indices 0.
- Top-level FSM:
  - IDLE: wait for start, then go to RUN. start is ignored in any state other than IDLE.
  - RUN: go to DONE when all channels are complete. Otherwise go to TIMEOUT when the cycle counter reaches MAX_CYC-1.
  - DONE and TIMEOUT: terminal; left only by reset. done=1 in both. timeout=1 only in TIMEOUT.
  - pass = (state==DONE) && all err_cnt==0 && !overrun.
- Per channel c, while in RUN:
  - exp_addr[c] = idx[c] (registered).
  - A sample is accepted when dut_valid[c]=1 and idx[c] < N_EXP.
  - On acceptance the data is captured into stage register S[c] with tag idx[c], and idx[c] increments.
  - Compare happens the following cycle: S[c].data vs exp_data[c] (which is mem[tag]). Latency from valid to counter update is 2 cycles.
  - Back-to-back valids every cycle are supported with no bubbles.
  - Channel complete = idx[c]==N_EXP and stage S[c] empty, so the last compare has landed.
- Valids in IDLE are ignored and not counted.
- Valid on a complete channel during RUN: sets overrun; the counters are unchanged.
- Valids in DONE or TIMEOUT are ignored.
- First-error capture: set once, on the first mismatch. If several channels mismatch in the same cycle, the lowest channel number wins.
- Counters saturate at 2**CW-1 and never wrap.
- reset asserted mid-RUN: everything returns to reset values on the next edge, including in-flight stage registers.

Optional Feature:
- Macro STRM_CHK_TOL_EN.
- Defined: a sample matches if |got - exp| <= TOL, comparing as unsigned DW-bit values with a DW+1-bit difference.
- Undefined: exact equality is required; the TOL parameter has no effect.

Test Plan:
- NCH=2, N_EXP=4, memories {10,20,30,40}; start, then 4 valids per channel with correct data -> done=1 and pass=1 in the cycle after the last compare; pass_cnt=4/4; err_cnt=0/0.
- Same setup, ch1 sample 2 driven 0x33 instead of 0x30 -> err_cnt[1]=1; first_err_ch=1, idx=2, got=0x33, exp=0x30; done=1, pass=0.
- Simultaneous mismatch on ch0 idx1 and ch1 idx1 -> first_err_ch=0; err_cnt=1/1.
- MAX_CYC=20, ch1 never asserts valid -> timeout=1 and done=1 at cycle 20 after start; pass=0.
- Fifth valid on ch0 after completion, with ch1 still running -> overrun=1; pass_cnt[0] stays 4; final pass=0.
- With STRM_CHK_TOL_EN, TOL=1: got 0x31 vs exp 0x30 -> counted as pass. Without the macro: the same stimulus gives err_cnt=1.
- Reset pulse mid-run after 2 samples -> all counters 0; state IDLE; a new start re-checks from idx 0.
